// File: rtl/accel_pkg.sv
// accel_pkg: shared definitions for the CPU accelerator slice.
//   - state_t      : divider FSM state encoding (3 bits)
//   - DIV_ZERO_Q   : quotient returned on divide by zero (all ones, sliced to width)
//   - ACCEL_ID_DIV : accel_id value the CPU-side decode uses to select the divider
package accel_pkg;

  typedef enum logic [2:0] {
    S_WAIT_A = 3'd0,
    S_WAIT_B = 3'd1,
    S_BUSY   = 3'd2,
    S_FIX    = 3'd3,
    S_OUT_Q  = 3'd4,
    S_OUT_R  = 3'd5
  } state_t;

  // Wide enough for any supported register width; users slice the low bits.
  localparam logic [63:0] DIV_ZERO_Q = {64{1'b1}};

  localparam logic [3:0] ACCEL_ID_DIV = 4'd2;

endpackage

// File: rtl/accel_div_step.sv
// accel_div_step: one combinational restoring-division step.
// Ports:
//   rem_i  : carried partial remainder (always < divisor, so WIDTH bits suffice)
//   div_i  : divisor magnitude
//   bit_i  : next dividend bit, MSB first
//   rem_o  : partial remainder after this step
//   qbit_o : quotient bit produced by this step
module accel_div_step
  import accel_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  // The shifted partial remainder needs WIDTH+1 bits before the trial subtract.
  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  assign shifted_s = {rem_i, bit_i};
  assign diff_s    = shifted_s - {1'b0, div_i};

  // Restore (keep the shifted value) when the trial subtraction went negative.
  always_comb begin
    rem_o  = shifted_s[WIDTH-1:0];
    qbit_o = 1'b0;
    if (diff_s[WIDTH] == 1'b0) begin
      rem_o  = diff_s[WIDTH-1:0];
      qbit_o = 1'b1;
    end else begin
      rem_o  = shifted_s[WIDTH-1:0];
      qbit_o = 1'b0;
    end
  end

endmodule

// File: rtl/accel_div.sv
// accel_div: iterative signed integer divider on the CPU accelerator port.
// The CPU writes the dividend then the divisor, waits (stalled via can_read),
// then reads the quotient then the remainder. Quotient truncates toward zero,
// remainder takes the sign of the dividend. Divide by zero yields all-ones
// quotient and the original dividend as remainder, with unchanged latency.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   write_enable  : decoded CPU write strobe; write_data : operand word
//   can_write     : high in WAIT_A / WAIT_B
//   read_enable   : decoded CPU read strobe; read_data : result word (comb)
//   can_read      : high in OUT_Q / OUT_R
//   busy          : high in BUSY / FIX
module accel_div
  import accel_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_enable,
  input  logic [WIDTH-1:0] write_data,
  output logic             can_write,
  input  logic             read_enable,
  output logic [WIDTH-1:0] read_data,
  output logic             can_read,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;       // original dividend, kept for div-by-zero
  logic [WIDTH-1:0] div_q, div_d;   // divisor magnitude
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder, then final remainder
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] step_rem_s;
  logic             step_qbit_s;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    // -(-2^(W-1)) wraps back to 2^(W-1), which is the correct unsigned magnitude.
    mag = v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  accel_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .div_i  (div_q),
    .bit_i  (quo_q[WIDTH-1]),
    .rem_o  (step_rem_s),
    .qbit_o (step_qbit_s)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_WAIT_A;
      cnt_q     <= {CNT_W{1'b0}};
      a_q       <= {WIDTH{1'b0}};
      div_q     <= {WIDTH{1'b0}};
      quo_q     <= {WIDTH{1'b0}};
      rem_q     <= {WIDTH{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      div_q     <= div_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    div_d     = div_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    case (state_q)
      S_WAIT_A: begin
        if (write_enable) begin
          a_d     = write_data;
          state_d = S_WAIT_B;
        end else begin
          state_d = S_WAIT_A;
        end
      end
      S_WAIT_B: begin
        if (write_enable) begin
          neg_quo_d = a_q[WIDTH-1] ^ write_data[WIDTH-1];
          neg_rem_d = a_q[WIDTH-1];
          dz_d      = (write_data == {WIDTH{1'b0}});
          quo_d     = mag(a_q);
          div_d     = mag(write_data);
          rem_d     = {WIDTH{1'b0}};
          cnt_d     = {CNT_W{1'b0}};
          state_d   = S_BUSY;
        end else begin
          state_d = S_WAIT_B;
        end
      end
      S_BUSY: begin
        rem_d = step_rem_s;
        quo_d = {quo_q[WIDTH-2:0], step_qbit_s};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_FIX: begin
        if (dz_q) begin
          quo_d = DIV_ZERO_Q[WIDTH-1:0];
          rem_d = a_q;
        end else begin
          quo_d = neg_quo_q ? (~quo_q + {{(WIDTH-1){1'b0}}, 1'b1}) : quo_q;
          rem_d = neg_rem_q ? (~rem_q + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_q;
        end
        state_d = S_OUT_Q;
      end
      S_OUT_Q: begin
        if (read_enable) begin
          state_d = S_OUT_R;
        end else begin
          state_d = S_OUT_Q;
        end
      end
      S_OUT_R: begin
        if (read_enable) begin
          state_d = S_WAIT_A;
        end else begin
          state_d = S_OUT_R;
        end
      end
      default: begin
        state_d = S_WAIT_A;
      end
    endcase
  end

  assign can_write = (state_q == S_WAIT_A) || (state_q == S_WAIT_B);
  assign can_read  = (state_q == S_OUT_Q)  || (state_q == S_OUT_R);
  assign busy      = (state_q == S_BUSY)   || (state_q == S_FIX);

  // Result word mux; zero whenever no result is being offered.
  always_comb begin
    read_data = {WIDTH{1'b0}};
    case (state_q)
      S_OUT_Q: read_data = quo_q;
      S_OUT_R: read_data = rem_q;
      default: read_data = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_accel_div.sv
module tb_accel_div;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         write_enable;
  logic [W-1:0] write_data;
  logic         can_write;
  logic         read_enable;
  logic [W-1:0] read_data;
  logic         can_read;
  logic         busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  accel_div #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .write_data   (write_data),
    .can_write    (can_write),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .can_read     (can_read),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Reference: signed division with plain integer arithmetic.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r);
    int ai;
    int bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) begin
      q = {W{1'b1}};
      r = a;
    end else begin
      q = W'(ai / bi);
      r = W'(ai % bi);
    end
  endtask

  task automatic write_word(input logic [W-1:0] w);
    int n = 0;
    while (!can_write && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!can_write) begin
      tests++;
      fails++;
      $display("FAIL write_timeout: can_write never rose");
    end
    write_enable = 1'b1;
    write_data   = w;
    @(negedge clk);
    write_enable = 1'b0;
    write_data   = W'($urandom);
  endtask

  // Called at the negedge of cycle 1 (first cycle after the divisor write).
  task automatic wait_result(input int start, output int lat, output int busy_cnt);
    lat = start;
    busy_cnt = 0;
    while (!can_read && lat < 60) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic read_word(input string name, input logic [W-1:0] exp, input int delay);
    int n = 0;
    while (!can_read && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (delay) @(negedge clk);
    check(name, read_data, exp);
    read_enable = 1'b1;
    @(negedge clk);
    read_enable = 1'b0;
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input int dq, input int dr);
    int lat;
    int bc;
    write_word(a);
    write_word(b);
    wait_result(1, lat, bc);
    check("latency", W'(lat), W'(18));
    check("busy_cycles", W'(bc), W'(17));
    read_word("quotient", eq, dq);
    read_word("remainder", er, dr);
    check("can_write_after", {{(W-1){1'b0}}, can_write}, {{(W-1){1'b0}}, 1'b1});
  endtask

  initial begin
    int lat;
    int bc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rq;
    logic [W-1:0] rr;

    vecs[0] = '{a: 16'd100,   b: 16'd7,     q: 16'h000E, r: 16'h0002};
    vecs[1] = '{a: 16'hFF9C,  b: 16'd7,     q: 16'hFFF2, r: 16'hFFFE};
    vecs[2] = '{a: 16'd100,   b: 16'hFFF9,  q: 16'hFFF2, r: 16'h0002};
    vecs[3] = '{a: 16'd5,     b: 16'd0,     q: 16'hFFFF, r: 16'h0005};
    vecs[4] = '{a: 16'h8000,  b: 16'hFFFF,  q: 16'h8000, r: 16'h0000};
    vecs[5] = '{a: 16'hFF9C,  b: 16'hFFF9,  q: 16'h000E, r: 16'hFFFE};

    rst = 1'b1;
    write_enable = 1'b0;
    write_data = '0;
    read_enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_can_write", {15'd0, can_write}, 16'd1);
    check("rst_can_read", {15'd0, can_read}, 16'd0);
    check("rst_read_data", read_data, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 0, 0);
    end

    // read_enable held high throughout; a write pulse during BUSY is ignored.
    read_enable = 1'b1;
    write_word(16'd1000);
    write_word(16'd37);
    repeat (4) @(negedge clk);
    write_enable = 1'b1;
    write_data = 16'h1234;
    @(negedge clk);
    write_enable = 1'b0;
    check("busy_after_stray_write", {15'd0, busy}, 16'd1);
    wait_result(6, lat, bc);
    check("hold_latency", W'(lat), 16'd18);
    check("hold_quotient", read_data, 16'd27);
    @(negedge clk);
    check("hold_can_read", {15'd0, can_read}, 16'd1);
    check("hold_remainder", read_data, 16'd1);
    @(negedge clk);
    check("hold_can_write", {15'd0, can_write}, 16'd1);
    read_enable = 1'b0;

    // Reset in the middle of BUSY.
    write_word(16'd1234);
    write_word(16'd5);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_can_write", {15'd0, can_write}, 16'd1);
    check("midrst_can_read", {15'd0, can_read}, 16'd0);
    check("midrst_read_data", read_data, 16'd0);
    check("midrst_busy", {15'd0, busy}, 16'd0);
    run_div(16'd81, 16'd9, 16'd9, 16'd0, 0, 0);

    // Randomized back-to-back operations with delayed reads.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 10 == 3) rb = 16'd0;
      if (i % 10 == 6) rb = 16'd1 + W'($urandom_range(0, 3));
      if (i % 10 == 8) ra = 16'h8000;
      model(ra, rb, rq, rr);
      run_div(ra, rb, rq, rr, $urandom_range(0, 5), $urandom_range(0, 5));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
